// File: rtl/lane_select_arb.sv
// ============================================================================
//  Module      : lane_select_arb
//  Description : Merges NUM_LANES valid/ready lanes onto one registered
//                valid/ready stream. Round-robin selection, or a single
//                static lane when FIXED_LANE >= 0. Saturating grant counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_select_arb #(
  parameter int NUM_LANES  = 4,
  parameter int WIDTH      = 8,
  parameter int FIXED_LANE = -1,
  parameter int CNT_W      = 16
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [NUM_LANES-1:0]                               in_valid,
  output logic [NUM_LANES-1:0]                               in_ready,
  input  logic [NUM_LANES*WIDTH-1:0]                         in_data,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [WIDTH-1:0]                                   out_data,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] out_lane,
  output logic [CNT_W-1:0]                                   grant_cnt
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [NUM_LANES-1:0] ONE_LANE = NUM_LANES'(1);

  logic [LW-1:0]    grant;
  logic             found;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [LW-1:0]    out_lane_q,  out_lane_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  // Out-of-range static lane is a configuration error, caught at elaboration.
  if (FIXED_LANE >= NUM_LANES) begin : g_bad_fixed
    $error("lane_select_arb: FIXED_LANE out of range");
  end

  if (FIXED_LANE >= 0) begin : g_fixed
    // Clamp keeps the index legal even when the elaboration check fires.
    localparam int FL = (FIXED_LANE < NUM_LANES) ? FIXED_LANE : 0;
    assign found = in_valid[FL];
    assign grant = LW'(FL);
  end else begin : g_rr
    logic [LW-1:0] ptr_q, ptr_d;

    // Scan lanes starting at the pointer; first valid lane wins.
    always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_LANES) idx = idx - NUM_LANES;
        if (!found && in_valid[idx]) begin
          grant = idx[LW-1:0];
          found = 1'b1;
        end
      end
    end

    // Pointer moves just past the granted lane, only on an accepted word.
    always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
        ptr_d = (grant == LW'(NUM_LANES - 1)) ? '0 : grant + 1'b1;
      end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
    end
  end

  // One-entry output stage: refill whenever empty or being drained.
  assign load_en  = !out_valid_q | out_ready;
  // rst_n gating keeps every ready low while reset is held.
  assign xfer     = rst_n & load_en & found;
  assign in_ready = xfer ? (ONE_LANE << grant) : '0;
  assign sel_data = in_data[grant*WIDTH +: WIDTH];

  // Next state of the output register and the saturating grant counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_lane_d  = grant;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register; async reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign grant_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_select_arb.sv
// ============================================================================
//  Module      : tb_lane_select_arb
//  Description : Directed vector bench for lane_select_arb: round-robin,
//                fixed-lane and small-counter saturation instances.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lane_select_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  logic [3:0]  m_in_ready, f_in_ready, s_in_ready;
  logic        m_ov, f_ov, s_ov;
  logic [7:0]  m_data, f_data, s_data;
  logic [1:0]  m_lane, f_lane, s_lane;
  logic [15:0] m_cnt, f_cnt;
  logic [1:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_select_arb #(.NUM_LANES(4), .WIDTH(8), .FIXED_LANE(-1), .CNT_W(16)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .out_valid(m_ov), .out_ready(out_ready),
    .out_data(m_data), .out_lane(m_lane), .grant_cnt(m_cnt));

  lane_select_arb #(.NUM_LANES(4), .WIDTH(8), .FIXED_LANE(2), .CNT_W(16)) u_fix (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_data(in_data), .out_valid(f_ov), .out_ready(out_ready),
    .out_data(f_data), .out_lane(f_lane), .grant_cnt(f_cnt));

  lane_select_arb #(.NUM_LANES(4), .WIDTH(8), .FIXED_LANE(-1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready),
    .out_data(s_data), .out_lane(s_lane), .grant_cnt(s_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        r;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [1:0]  exp_lane;
    logic [7:0]  exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // Lane i carries i*0x11.
    in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
    in_valid  = 4'hF;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Fairness, sparse, backpressure, drain, idle, pointer-wrap vectors.
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h00, 16'd1};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 16'd2};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 8'h22, 16'd3};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 8'h33, 16'd4};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h00, 16'd5};
    tbl[5]  = '{4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 16'd6};
    tbl[6]  = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 8'h33, 16'd7};
    tbl[7]  = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11, 16'd8};
    tbl[8]  = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 8'h33, 16'd9};
    tbl[9]  = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 8'h33, 16'd9};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 8'h33, 16'd9};
    tbl[11] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 8'h33, 16'd9};
    tbl[12] = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 8'h00, 16'd10};
    tbl[13] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00, 16'd10};
    tbl[14] = '{4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00, 16'd10};
    tbl[15] = '{4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 8'h22, 16'd11};

    // Reset held with every lane valid.
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(m_ov), 32'd0);
    chk("reset in_ready", 32'(m_in_ready), 32'h0);
    chk("reset fixed in_ready", 32'(f_in_ready), 32'h0);
    chk("reset grant_cnt", 32'(m_cnt), 32'd0);
    chk("reset out_data", 32'(m_data), 32'd0);
    chk("reset out_lane", 32'(m_lane), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      in_valid  = tbl[i].v;
      out_ready = tbl[i].r;
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(m_in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(m_ov), 32'(tbl[i].exp_ov));
      chk($sformatf("vec%0d out_lane", i), 32'(m_lane), 32'(tbl[i].exp_lane));
      chk($sformatf("vec%0d out_data", i), 32'(m_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d grant_cnt", i), 32'(m_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d sat_cnt", i), 32'(s_cnt),
          (tbl[i].exp_cnt > 16'd3) ? 32'd3 : 32'(tbl[i].exp_cnt));
    end

    // Asynchronous reset between edges while a word is held (pointer is at 3).
    @(negedge clk);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(m_ov), 32'd0);
    chk("midrst in_ready", 32'(m_in_ready), 32'h0);
    chk("midrst grant_cnt", 32'(m_cnt), 32'd0);
    chk("midrst out_data", 32'(m_data), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("postrst in_ready", 32'(m_in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("postrst out_lane", 32'(m_lane), 32'd0);
    chk("postrst out_valid", 32'(m_ov), 32'd1);
    chk("postrst grant_cnt", 32'(m_cnt), 32'd1);

    // Fixed-lane instance from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid  = 4'hF;
      out_ready = 1'b1;
      #1;
      chk($sformatf("fix%0d in_ready", c), 32'(f_in_ready), 32'h4);
      @(posedge clk);
      #1;
      chk($sformatf("fix%0d out_lane", c), 32'(f_lane), 32'd2);
      chk($sformatf("fix%0d out_data", c), 32'(f_data), 32'h22);
      chk($sformatf("fix%0d grant_cnt", c), 32'(f_cnt), 32'(c + 1));
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    chk("fix stall in_ready", 32'(f_in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("fix stall out_valid", 32'(f_ov), 32'd1);
    chk("fix stall out_lane", 32'(f_lane), 32'd2);
    @(negedge clk);
    in_valid  = 4'hB;
    out_ready = 1'b1;
    #1;
    chk("fix nolane in_ready", 32'(f_in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("fix drain out_valid", 32'(f_ov), 32'd0);
    chk("fix drain out_data", 32'(f_data), 32'h22);
    chk("fix drain grant_cnt", 32'(f_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
